// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   SEG_BLANK  - all segments off (active-low)
//   SEG_TABLE  - hex 0..F to active-low {g,f,e,d,c,b,a} patterns
//   hex_to_seg - table lookup helper
//   scan_state_e - IDLE/SCAN encoding of the scan FSM
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 15 first so SEG_TABLE[n] is the pattern for hex n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low segment decoder.
//   hex  in  4  nibble to display
//   segs out 7  active-low {g,f,e,d,c,b,a}
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] segs
);

    assign segs = hex_to_seg(hex);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a common-anode 7-segment
// display. One digit is lit per refresh tick; the input value is captured
// once per frame so a frame never mixes old and new digits.
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   enable     in   1 = scan, 0 = display dark
//   value      in   4*NUM_DIGITS hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in      in   NUM_DIGITS decimal-point requests
//   anode      out  active-low digit select
//   segs       out  active-low {g,f,e,d,c,b,a}
//   dp         out  active-low decimal point
//   frame_done out  one-cycle pulse on wrap from last digit to digit 0
// Optional feature: define LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int SCAN_HZ    = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [6:0]                segs,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = (TICK_DIV >= 2) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    if (TICK_DIV < 2) begin : g_bad_tick
        $error("seg7_scan_driver: CLK_HZ/SCAN_HZ must be at least 2");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
    end

    scan_state_e                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]    snap_val_q, snap_val_d;
    logic [NUM_DIGITS-1:0]      snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]      anode_q, anode_d;
    logic [6:0]                 segs_q, segs_d;
    logic                       dp_q, dp_d;
    logic                       fd_q, fd_d;

    logic                       tick, wrap;
    logic [3:0]                 cur_nib;
    logic                       cur_dp, cur_lz, blank;
    logic [6:0]                 cur_seg;

    // Scan FSM, prescaler and snapshot.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_val_d = snap_val_q;
        snap_dp_d  = snap_dp_q;
        fd_d       = 1'b0;
        tick       = 1'b0;
        wrap       = 1'b0;
        if (!enable || state_q == ST_IDLE) begin
            // Idle keeps the snapshot live so a (re)start shows the current value.
            state_d    = enable ? ST_SCAN : ST_IDLE;
            cnt_d      = '0;
            idx_d      = '0;
            snap_val_d = value;
            snap_dp_d  = dp_in;
        end else begin
            tick  = (cnt_q == CNT_MAX);
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                wrap  = (idx_q == IDX_MAX);
                idx_d = wrap ? '0 : idx_q + IDX_W'(1);
                if (wrap) begin
                    snap_val_d = value;
                    snap_dp_d  = dp_in;
                    fd_d       = 1'b1;
                end
            end
        end
    end

`ifdef LZ_BLANK_EN
    // lead_zero[i]: nibble i and every nibble above it are zero.
    logic [NUM_DIGITS-1:0] lead_zero;
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run & (snap_val_d[4*i +: 4] == 4'h0);
            lead_zero[i] = run;
        end
    end
`endif

    // Select the digit that will be driven after this edge. Outputs are
    // built from the next-state snapshot so a wrap shows the new frame at once.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                cur_nib = snap_val_d[4*i +: 4];
                cur_dp  = snap_dp_d[i];
`ifdef LZ_BLANK_EN
                cur_lz  = lead_zero[i] && (i != 0);
`endif
            end
        end
        // A requested decimal point keeps its digit visible.
        blank = cur_lz && !cur_dp;
    end

    seg7_decode u_decode (
        .hex  (cur_nib),
        .segs (cur_seg)
    );

    always_comb begin
        anode_d = '1;
        segs_d  = SEG_BLANK;
        dp_d    = 1'b1;
        if (state_d == ST_SCAN && !blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == IDX_W'(i)) anode_d[i] = 1'b0;
            end
            segs_d = cur_seg;
            dp_d   = ~cur_dp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            anode_q    <= '1;
            segs_q     <= SEG_BLANK;
            dp_q       <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_val_q <= snap_val_d;
            snap_dp_q  <= snap_dp_d;
            anode_q    <= anode_d;
            segs_q     <= segs_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    assign anode      = anode_q;
    assign segs       = segs_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: TICK_DIV = 4 with a 4-digit and a 1-digit
// instance. Leading-zero cases are checked when LZ_BLANK_EN is defined.
module tb_seg7_scan_driver;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00;
    localparam logic [6:0] SA = 7'h08, SF = 7'h0E, SOFF = 7'h7F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, enable1;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  value1;
    logic [0:0]  dp_in1;
    logic [3:0]  anode;
    logic [6:0]  segs, segs1;
    logic        dp, frame_done, dp1, frame_done1;
    logic [0:0]  anode1;

    int n_pass  = 0;
    int n_total = 0;

    seg7_scan_driver #(.NUM_DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(250)) dut (
        .clk(clk), .reset(reset), .enable(enable), .value(value), .dp_in(dp_in),
        .anode(anode), .segs(segs), .dp(dp), .frame_done(frame_done)
    );

    seg7_scan_driver #(.NUM_DIGITS(1), .CLK_HZ(1000), .SCAN_HZ(250)) dut1 (
        .clk(clk), .reset(reset), .enable(enable1), .value(value1), .dp_in(dp_in1),
        .anode(anode1), .segs(segs1), .dp(dp1), .frame_done(frame_done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One digit slot = 4 clocks; frame_done may only be high on the first.
    task automatic expect_slot(input string name, input logic [3:0] an, input logic [6:0] sg,
                               input logic d, input logic fd);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("%s.c%0d.anode", name, k), 32'(anode), 32'(an));
            check($sformatf("%s.c%0d.segs", name, k), 32'(segs), 32'(sg));
            check($sformatf("%s.c%0d.dp", name, k), 32'(dp), 32'(d));
            check($sformatf("%s.c%0d.fd", name, k), 32'(frame_done), (k == 0) ? 32'(fd) : 32'd0);
        end
    endtask

    task automatic restart(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        value  = v;
        dp_in  = d;
        enable = 1'b1;
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic [3:0]  anode;
        logic [6:0]  segs;
        logic        dp;
        logic        fd;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int fd_cnt, last_fd;
        reset = 1'b1; enable = 1'b0; enable1 = 1'b0;
        value = 16'h0; dp_in = 4'h0; value1 = 4'h7; dp_in1 = 1'b0;

        // Reset state
        #1;
        check("rst.anode", 32'(anode), 32'hF);
        check("rst.segs", 32'(segs), 32'(SOFF));
        check("rst.dp", 32'(dp), 32'd1);
        check("rst.fd", 32'(frame_done), 32'd0);
        check("rst.anode1", 32'(anode1), 32'd1);

        // Frames 0,1 of 12AF; mid frame 2 the input becomes 0003 and only
        // shows after the following wrap.
        for (int i = 0; i < 10; i++) tbl[i].value = 16'h12AF;
        for (int i = 0; i < 10; i++) tbl[i].dp_in = 4'b0100;
        for (int i = 10; i < 16; i++) tbl[i].value = 16'h0003;
        for (int i = 10; i < 16; i++) tbl[i].dp_in = 4'b0000;
        for (int f = 0; f < 3; f++) begin
            tbl[4*f+0].anode = 4'b1110; tbl[4*f+0].segs = SF; tbl[4*f+0].dp = 1'b1; tbl[4*f+0].fd = (f != 0);
            tbl[4*f+1].anode = 4'b1101; tbl[4*f+1].segs = SA; tbl[4*f+1].dp = 1'b1; tbl[4*f+1].fd = 1'b0;
            tbl[4*f+2].anode = 4'b1011; tbl[4*f+2].segs = S2; tbl[4*f+2].dp = 1'b0; tbl[4*f+2].fd = 1'b0;
            tbl[4*f+3].anode = 4'b0111; tbl[4*f+3].segs = S1; tbl[4*f+3].dp = 1'b1; tbl[4*f+3].fd = 1'b0;
        end
        tbl[12].anode = 4'b1110; tbl[12].segs = S3; tbl[12].dp = 1'b1; tbl[12].fd = 1'b1;
`ifdef LZ_BLANK_EN
        for (int i = 13; i < 16; i++) begin
            tbl[i].anode = 4'b1111; tbl[i].segs = SOFF; tbl[i].dp = 1'b1; tbl[i].fd = 1'b0;
        end
`else
        tbl[13].anode = 4'b1101; tbl[14].anode = 4'b1011; tbl[15].anode = 4'b0111;
        for (int i = 13; i < 16; i++) begin
            tbl[i].segs = S0; tbl[i].dp = 1'b1; tbl[i].fd = 1'b0;
        end
`endif

        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        value = 16'h12AF; dp_in = 4'b0100;
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            value = tbl[i].value;
            dp_in = tbl[i].dp_in;
            expect_slot($sformatf("vec%0d", i), tbl[i].anode, tbl[i].segs, tbl[i].dp, tbl[i].fd);
        end

        // Enable low for 3 clocks mid-frame, value changed while dark.
        @(negedge clk); @(negedge clk);
        enable = 1'b0;
        value = 16'hBCDE; dp_in = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("dis.c%0d.anode", k), 32'(anode), 32'hF);
            check($sformatf("dis.c%0d.segs", k), 32'(segs), 32'(SOFF));
            check($sformatf("dis.c%0d.dp", k), 32'(dp), 32'd1);
            if (k == 1) value = 16'h5678;
        end
        enable = 1'b1;
        expect_slot("reen.d0", 4'b1110, S8, 1'b1, 1'b0);
        expect_slot("reen.d1", 4'b1101, S7, 1'b1, 1'b0);
        expect_slot("reen.d2", 4'b1011, S6, 1'b1, 1'b0);
        expect_slot("reen.d3", 4'b0111, S5, 1'b0, 1'b0);

        // Asynchronous reset mid-scan, right after a wrap pulse.
        @(negedge clk);
        check("prerst.fd", 32'(frame_done), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst.anode", 32'(anode), 32'hF);
        check("arst.segs", 32'(segs), 32'(SOFF));
        check("arst.dp", 32'(dp), 32'd1);
        check("arst.fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        expect_slot("postrst.d0", 4'b1110, S8, 1'b1, 1'b0);

        // frame_done: exactly one pulse every 16 clocks.
        fd_cnt = 0; last_fd = -1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (frame_done) begin
                fd_cnt++;
                if (last_fd >= 0) check("fd.gap", 32'(c - last_fd), 32'd16);
                last_fd = c;
            end
        end
        check("fd.count", 32'(fd_cnt), 32'd4);

`ifdef LZ_BLANK_EN
        restart(16'h0030, 4'b0000);
        expect_slot("lz30.d0", 4'b1110, S0, 1'b1, 1'b0);
        expect_slot("lz30.d1", 4'b1101, S3, 1'b1, 1'b0);
        expect_slot("lz30.d2", 4'b1111, SOFF, 1'b1, 1'b0);
        expect_slot("lz30.d3", 4'b1111, SOFF, 1'b1, 1'b0);
        restart(16'h0000, 4'b0000);
        expect_slot("lz0.d0", 4'b1110, S0, 1'b1, 1'b0);
        expect_slot("lz0.d1", 4'b1111, SOFF, 1'b1, 1'b0);
        expect_slot("lz0.d2", 4'b1111, SOFF, 1'b1, 1'b0);
        expect_slot("lz0.d3", 4'b1111, SOFF, 1'b1, 1'b0);
        restart(16'h0000, 4'b0100);
        expect_slot("lzdp.d0", 4'b1110, S0, 1'b1, 1'b0);
        expect_slot("lzdp.d1", 4'b1111, SOFF, 1'b1, 1'b0);
        expect_slot("lzdp.d2", 4'b1011, S0, 1'b0, 1'b0);
        expect_slot("lzdp.d3", 4'b1111, SOFF, 1'b1, 1'b0);
`else
        restart(16'h0030, 4'b0000);
        expect_slot("nolz.d0", 4'b1110, S0, 1'b1, 1'b0);
        expect_slot("nolz.d1", 4'b1101, S3, 1'b1, 1'b0);
        expect_slot("nolz.d2", 4'b1011, S0, 1'b1, 1'b0);
        expect_slot("nolz.d3", 4'b0111, S0, 1'b1, 1'b0);
`endif

        // Single digit: always selected, every tick wraps.
        @(negedge clk);
        check("one.idle.anode", 32'(anode1), 32'd1);
        enable1 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("one.c%0d.anode", k), 32'(anode1), 32'd0);
            check($sformatf("one.c%0d.segs", k), 32'(segs1), (k < 9) ? 32'(S7) : 32'(SA));
            check($sformatf("one.c%0d.dp", k), 32'(dp1), 32'd1);
            check($sformatf("one.c%0d.fd", k), 32'(frame_done1),
                  (k >= 5 && (k - 1) % 4 == 0) ? 32'd1 : 32'd0);
            if (k == 6) value1 = 4'hA;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
